stream_rr_mux: RTL and testbench
================================

STREAM_RR_MUX -- requirements
Module: stream_rr_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data bits per channel (min 1).
REQ-002 The module SHALL have parameter NUM_CH, default 4, meaning number of input channels (min 1; CH_W = max(1, clog2(NUM_CH))).
REQ-003 The module SHALL have port clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port in_data_i  input  NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
REQ-006 The module SHALL have port in_valid_i  input  NUM_CH  per-channel valid.
REQ-007 The module SHALL have port in_last_i  input  NUM_CH  per-channel end-of-packet marker.
REQ-008 The module SHALL have port in_ready_o  output  NUM_CH  per-channel ready; at most one bit high.
REQ-009 The module SHALL have port out_data_o  output  WIDTH  registered selected data.
REQ-010 The module SHALL have port out_valid_o  output  1  output valid.
REQ-011 The module SHALL have port out_last_o  output  1  registered last of the selected beat.
REQ-012 The module SHALL have port out_ch_o  output  CH_W  index of the source channel of the current output beat.
REQ-013 The module SHALL have port out_ready_i  input  1  downstream ready.

Function
REQ-014 A transfer SHALL occur on a channel/output when valid and ready are both high at a rising edge.
REQ-015 load = !out_valid_o || out_ready_i; in_ready_o SHALL equal onehot(grant) when load and in_valid_i[grant], else zero.
REQ-016 An accepted beat SHALL appear on out_data_o/out_last_o/out_ch_o with out_valid_o=1 exactly 1 cycle later (latency 1, throughput 1 beat/cycle).
REQ-017 While out_valid_o=1 and out_ready_i=0, all out_* SHALL hold stable.
REQ-018 If load and no channel is granted, out_valid_o SHALL go 0 next cycle; out_data_o holds its last value.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod NUM_CH, first asserted valid wins; last_granted updates only on an accepted beat.
REQ-020 Arbiter SHALL have states ARB (free to choose) and LOCK (grant held); ARB->LOCK on accepted beat with in_last=0; LOCK->ARB on accepted beat with in_last=1.
REQ-021 In LOCK, grant SHALL stay on the locked channel even if its valid drops; other channels SHALL see in_ready_o=0.
REQ-022 NUM_CH=1 SHALL degenerate to a registered pipeline stage; out_ch_o SHALL be 0.
REQ-023 Wrap-around: after granting channel NUM_CH-1, search SHALL resume at channel 0.

Reset
REQ-024 When rst_i=1 at a rising edge: out_valid_o=0, out_last_o=0, out_data_o=0, out_ch_o=0, state=ARB, last_granted=NUM_CH-1 (channel 0 wins first).
REQ-025 in_ready_o SHALL be 0 during any cycle rst_i=1; reset mid-packet SHALL discard the lock and the held output beat.

Configuration
REQ-026 Macro STREAM_RR_MUX_PKT_LOCK_EN defined: LOCK state and REQ-020/021 behaviour SHALL be compiled in.
REQ-027 Macro STREAM_RR_MUX_PKT_LOCK_EN undefined: no LOCK state; re-arbitrate every beat per REQ-019; in_last passes through unchanged.

Structure
REQ-028 Shared package stream_mux_pkg SHALL hold the arbiter state enum (ARB, LOCK) and a CH_W width helper constant function.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last_granted, hold; output one-hot grant and index).
REQ-030 Top SHALL contain only the output register, load logic and data selection.

Verification (WIDTH=8, NUM_CH=4, lock enabled unless stated)
REQ-031 Reset: drive rst_i=1 two cycles with all valids high -> in_ready_o=0000, out_valid_o=0, out_data_o=0x00.
REQ-032 Fairness: all valids high, last=1, out_ready_i=1, ch c data=0x10+c -> output sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles, out_ch_o 0,1,2,3,0.
REQ-033 Backpressure: out_ready_i=0 for 3 cycles with ch2 beat 0xA5 held -> out_data_o=0xA5 stable, in_ready_o=0000; release -> next beat accepted same cycle.
REQ-034 Packet lock: ch1 sends 3 beats (last on 3rd) while ch0,ch3 valid, ch1 valid drops 1 cycle mid-packet -> no ch0/ch3 beat interleaved; ch3 granted after ch1 last.
REQ-035 Lock disabled build, same stimulus as REQ-034 -> beats interleave round-robin 1,3,0,1,...
REQ-036 Reset mid-packet: assert rst_i after ch2 beat 1 of 3 -> out_valid_o=0 next cycle; afterwards ch0 wins first with all valids high.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and helpers for the stream_rr_mux slice.
// Holds the arbiter state encoding and the channel-index width helper used
// by both the top level and the round-robin arbiter.

package stream_mux_pkg;

  // Arbiter state: ARB = free to pick a new channel, LOCK = packet in flight
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Width of a channel index; a single channel still gets a 1-bit index
  function automatic int ch_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/stream_rr_mux_arbiter.sv
// rr_arbiter: combinational round-robin grant for stream_rr_mux.
// The search starts one past the last granted channel and wraps, so the
// channel served most recently has the lowest priority. When i_hold is set
// the grant is pinned to i_last_granted regardless of the request vector;
// this is how an open packet keeps its channel.

module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_last_granted,
  input  logic              i_hold,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_index
);

  // Rotating priority search, or a pinned grant while a packet is locked
  always_comb begin
    logic [NUM_CH-1:0] v_grant;
    logic [CH_W-1:0]   v_index;
    logic [CH_W-1:0]   v_idx_w;
    logic              v_found;
    logic              v_hit;
    int                v_idx;
    v_grant = '0;
    v_index = '0;
    v_idx_w = '0;
    v_found = 1'b0;
    v_hit   = 1'b0;
    v_idx   = 0;
    if (i_hold) begin
      v_grant[i_last_granted] = 1'b1;
      v_index                 = i_last_granted;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        v_idx            = (int'(i_last_granted) + k) % NUM_CH;
        v_idx_w          = CH_W'(v_idx);
        v_hit            = !v_found && i_req[v_idx_w];
        v_grant[v_idx_w] = v_hit;
        v_index          = v_hit ? v_idx_w : v_index;
        v_found          = v_found | v_hit;
      end
    end
    o_grant = v_grant;
    o_index = v_index;
  end

endmodule

// File: rtl/stream_rr_mux.sv
// stream_rr_mux: N-channel valid/ready stream multiplexer with a
// round-robin arbiter and a single registered output stage (latency 1,
// full throughput). Optional packet locking is compiled in with the macro
// STREAM_RR_MUX_PKT_LOCK_EN: once a channel sends a beat without last, it
// keeps the grant until its last beat. Without the macro every beat is
// re-arbitrated and in_last is only carried through to out_last_o.

module stream_rr_mux
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH*WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]       in_valid_i,
  input  logic [NUM_CH-1:0]       in_last_i,
  output logic [NUM_CH-1:0]       in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    out_valid_o,
  output logic                    out_last_o,
  output logic [CH_W-1:0]         out_ch_o,
  input  logic                    out_ready_i
);

  logic              w_load;
  logic              w_sel_valid;
  logic              w_accept;
  logic              w_hold;
  logic              w_sel_last;
  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_index;
  logic [WIDTH-1:0]  w_sel_data;

  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_last_granted;

`ifdef STREAM_RR_MUX_PKT_LOCK_EN
  arb_state_e        r_state;
  assign w_hold = (r_state == LOCK);
`else
  assign w_hold = 1'b0;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .i_req          (in_valid_i),
    .i_last_granted (r_last_granted),
    .i_hold         (w_hold),
    .o_grant        (w_grant),
    .o_index        (w_index)
  );

  // Load decision and handshake: the output stage can take a beat when it is
  // empty or being drained; ready is never raised while reset is asserted
  always_comb begin
    w_load      = !r_out_valid || out_ready_i;
    w_sel_valid = |(w_grant & in_valid_i);
    w_accept    = w_load && w_sel_valid && !rst_i;
    if (w_accept) begin
      in_ready_o = w_grant;
    end else begin
      in_ready_o = '0;
    end
  end

  // Data/last selection from the granted channel
  always_comb begin
    w_sel_data = in_data_i[int'(w_index)*WIDTH +: WIDTH];
    w_sel_last = in_last_i[w_index];
  end

  // Output register, last-granted pointer and (optionally) packet lock state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_out_ch       <= '0;
      r_last_granted <= CH_W'(NUM_CH - 1);
`ifdef STREAM_RR_MUX_PKT_LOCK_EN
      r_state        <= ARB;
`endif
    end else if (w_load) begin
      // An empty load cycle drops valid but leaves the last beat visible
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_data     <= w_sel_data;
        r_out_last     <= w_sel_last;
        r_out_ch       <= w_index;
        r_last_granted <= w_index;
`ifdef STREAM_RR_MUX_PKT_LOCK_EN
        r_state        <= w_sel_last ? ARB : LOCK;
`endif
      end
    end
  end

  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign out_last_o  = r_out_last;
  assign out_ch_o    = r_out_ch;

endmodule

// File: tb/tb_stream_rr_mux.sv
// tb_stream_rr_mux: self-checking bench for stream_rr_mux (WIDTH=8, NUM_CH=4).
// Table rows give per-cycle inputs and the expected in_ready/out_valid;
// accepted beats are pushed to a scoreboard and compared when the DUT
// presents them with out_ready_i high. Expectations for the packet sequence
// follow whether STREAM_RR_MUX_PKT_LOCK_EN is defined for the build.

module tb_stream_rr_mux;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_valid_i;
  logic [3:0]  in_last_i;
  logic [3:0]  in_ready_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_last_o;
  logic [1:0]  out_ch_o;
  logic        out_ready_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] ch;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        cov;
    logic        ov;
    logic        cdat;
    logic [7:0]  dat;
  } vec_t;

  vec_t tbl[$];

`ifdef STREAM_RR_MUX_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  stream_rr_mux #(
    .WIDTH  (8),
    .NUM_CH (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_ch_o    (out_ch_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic ordy, input logic [3:0] rdy, input logic cov,
                              input logic ov, input logic cdat, input logic [7:0] dat);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.ordy = ordy; r.rdy = rdy;
    r.cov = cov; r.ov = ov; r.cdat = cdat; r.dat = dat;
    return r;
  endfunction

  // One clock cycle: drive, check at the falling edge, update scoreboard
  task automatic do_cycle(input logic rst, input logic [3:0] v, input logic [3:0] l,
                          input logic [31:0] d, input logic ordy, input logic [3:0] exp_rdy,
                          input logic cov, input logic exp_ov, input logic cdat,
                          input logic [7:0] exp_dat);
    beat_t b;
    rst_i       = rst;
    in_valid_i  = v;
    in_last_i   = l;
    in_data_i   = d;
    out_ready_i = ordy;
    @(negedge clk_i);
    check("in_ready", {28'd0, in_ready_o}, {28'd0, exp_rdy});
    if (cov) check("out_valid", {31'd0, out_valid_o}, {31'd0, exp_ov});
    if (cdat) check("out_data_hold", {24'd0, out_data_o}, {24'd0, exp_dat});
    if (!rst && out_valid_o && ordy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: actual data=0x%0h ch=%0d expected no beat", out_data_o, out_ch_o);
      end else begin
        b = sb.pop_front();
        check("sb_data", {24'd0, out_data_o}, {24'd0, b.data});
        check("sb_last", {31'd0, out_last_o}, {31'd0, b.last});
        check("sb_ch", {30'd0, out_ch_o}, {30'd0, b.ch});
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (exp_rdy[c]) begin
        b.data = d[c*8 +: 8];
        b.last = l[c];
        b.ch   = 2'(c);
        sb.push_back(b);
      end
    end
    @(posedge clk_i);
    #1;
    if (rst) sb.delete();
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 4'hF;
    in_last_i   = 4'hF;
    in_data_i   = 32'h0;
    out_ready_i = 1'b1;

    // Fairness: all channels valid with last, data 0x10+c
    tbl.push_back(mk(4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13121110, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13121110, 1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13121110, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'h0, 4'h0, 32'h13121110, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00));
    // Backpressure: ch2 beat 0xA5 held three cycles, then released
    tbl.push_back(mk(4'h4, 4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13B61110, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'hA5));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13B61110, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'hA5));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13B61110, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 8'hA5));
    tbl.push_back(mk(4'hF, 4'hF, 32'h13B61110, 1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 8'hA5));
    tbl.push_back(mk(4'h0, 4'h0, 32'h13B61110, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 8'h13));
    tbl.push_back(mk(4'h0, 4'h0, 32'h13B61110, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00));
    // Packet: ch0 single beat moves the pointer, then ch1 3-beat packet
    tbl.push_back(mk(4'h1, 4'h1, 32'h40003120, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00));
    tbl.push_back(mk(4'hB, 4'h9, 32'h40003120, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'h9, 4'h9, 32'h40003120, 1'b1, LOCK_EN ? 4'h0 : 4'h8,
                     1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'hB, 4'h9, 32'h40003220, 1'b1, LOCK_EN ? 4'h2 : 4'h1,
                     1'b1, LOCK_EN ? 1'b0 : 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'hB, 4'hB, 32'h40003320, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'h9, 4'h9, 32'h40003320, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(4'h0, 4'h0, 32'h40003320, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00));

    // Reset with all valids high: no ready, outputs cleared
    do_cycle(1'b1, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b1, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_out_data", {24'd0, out_data_o}, 32'd0);
    check("rst_out_last", {31'd0, out_last_o}, 32'd0);
    check("rst_out_ch", {30'd0, out_ch_o}, 32'd0);

    foreach (tbl[i]) begin
      do_cycle(1'b0, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].ordy, tbl[i].rdy,
               tbl[i].cov, tbl[i].ov, tbl[i].cdat, tbl[i].dat);
    end

    // Reset mid-packet: ch2 opens a packet, reset drops it and the held beat
    do_cycle(1'b0, 4'h4, 4'h0, 32'h00510000, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 8'h00);
    do_cycle(1'b1, 4'hF, 4'h0, 32'h13121110, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00);
    do_cycle(1'b0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 8'h00);
    do_cycle(1'b0, 4'h0, 4'h0, 32'h13121110, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00);
    do_cycle(1'b0, 4'h0, 4'h0, 32'h13121110, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00);

    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
